// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the memory slave.
interface mem_access_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack bus, aligns and
// extends load data, forwards ALU results, and stalls Execute while busy.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  EX_rd,
  input  logic        EX_rd_vld,
  input  logic [31:0] EX_x_rd,
  input  logic [31:0] EX_MEM_addr,
  input  logic [3:0]  EX_MEM_rden,
  input  logic        EX_MEM_rden_SEXT,
  input  logic [3:0]  EX_MEM_wren,
  input  logic [31:0] EX_MEM_wrdata,
  mem_access_if.master dbus,
  output logic        MEM_stall,
  output logic        MEM_bus_err,
  output logic [4:0]  MEM_rd,
  output logic        MEM_rd_vld,
  output logic [31:0] MEM_x_rd
);

  localparam int unsigned CNT_RAW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             sext_q, sext_d;
  logic [4:0]       rd_cap_q, rd_cap_d;
  logic             rd_vld_cap_q, rd_vld_cap_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             mem_rd_vld_q, mem_rd_vld_d;
  logic [31:0]      mem_x_rd_q, mem_x_rd_d;
  logic             bus_err_q, bus_err_d;

  logic             access;
  logic             is_store;
  logic             timeout_hit;
  logic [31:0]      load_val;
  logic             unused_addr_lsbs;

  // Word-aligned bus address drops the byte offset; lanes are selected by the mask.
  assign unused_addr_lsbs = ^EX_MEM_addr[1:0];

  assign access      = (|EX_MEM_rden) || (|EX_MEM_wren);
  assign is_store    = |EX_MEM_wren;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Extract the addressed field from the read word and extend it to 32 bits.
  always_comb begin
    load_val = 32'h0;
    unique case (be_q)
      4'b0001: load_val = sext_q ? {{24{dbus.dbus_rdata[7]}},  dbus.dbus_rdata[7:0]}
                                 : {24'h0, dbus.dbus_rdata[7:0]};
      4'b0010: load_val = sext_q ? {{24{dbus.dbus_rdata[15]}}, dbus.dbus_rdata[15:8]}
                                 : {24'h0, dbus.dbus_rdata[15:8]};
      4'b0100: load_val = sext_q ? {{24{dbus.dbus_rdata[23]}}, dbus.dbus_rdata[23:16]}
                                 : {24'h0, dbus.dbus_rdata[23:16]};
      4'b1000: load_val = sext_q ? {{24{dbus.dbus_rdata[31]}}, dbus.dbus_rdata[31:24]}
                                 : {24'h0, dbus.dbus_rdata[31:24]};
      4'b0011: load_val = sext_q ? {{16{dbus.dbus_rdata[15]}}, dbus.dbus_rdata[15:0]}
                                 : {16'h0, dbus.dbus_rdata[15:0]};
      4'b1100: load_val = sext_q ? {{16{dbus.dbus_rdata[31]}}, dbus.dbus_rdata[31:16]}
                                 : {16'h0, dbus.dbus_rdata[31:16]};
      4'b1111: load_val = dbus.dbus_rdata;
      default: load_val = 32'h0;
    endcase
  end

  // Next-state, next-register values and the combinational stall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    sext_d       = sext_q;
    rd_cap_d     = rd_cap_q;
    rd_vld_cap_d = rd_vld_cap_q;
    mem_rd_d     = mem_rd_q;
    mem_rd_vld_d = mem_rd_vld_q;
    mem_x_rd_d   = mem_x_rd_q;
    bus_err_d    = 1'b0;
    MEM_stall    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!access) begin
          mem_rd_d     = EX_rd;
          mem_rd_vld_d = EX_rd_vld;
          mem_x_rd_d   = EX_x_rd;
        end else begin
          // A store takes priority when both masks are set.
          MEM_stall    = 1'b1;
          addr_d       = {EX_MEM_addr[31:2], 2'b00};
          we_d         = is_store;
          be_d         = is_store ? EX_MEM_wren : EX_MEM_rden;
          wdata_d      = EX_MEM_wrdata;
          sext_d       = EX_MEM_rden_SEXT;
          rd_cap_d     = EX_rd;
          rd_vld_cap_d = EX_rd_vld;
          req_d        = 1'b1;
          mem_rd_vld_d = 1'b0;
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        if (dbus.dbus_ack) begin
          req_d        = 1'b0;
          mem_rd_d     = rd_cap_q;
          mem_rd_vld_d = rd_vld_cap_q;
          if (!we_q) begin
            mem_x_rd_d = load_val;
          end
          state_d      = IDLE;
        end else if (timeout_hit) begin
          req_d        = 1'b0;
          bus_err_d    = 1'b1;
          mem_rd_vld_d = 1'b0;
          state_d      = IDLE;
        end else begin
          MEM_stall    = 1'b1;
          mem_rd_vld_d = 1'b0;
          if (TIMEOUT != 0) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, withdrawing any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      sext_q       <= 1'b0;
      rd_cap_q     <= 5'h0;
      rd_vld_cap_q <= 1'b0;
      mem_rd_q     <= 5'h0;
      mem_rd_vld_q <= 1'b0;
      mem_x_rd_q   <= 32'h0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      sext_q       <= sext_d;
      rd_cap_q     <= rd_cap_d;
      rd_vld_cap_q <= rd_vld_cap_d;
      mem_rd_q     <= mem_rd_d;
      mem_rd_vld_q <= mem_rd_vld_d;
      mem_x_rd_q   <= mem_x_rd_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_be    = be_q;
  assign dbus.dbus_wdata = wdata_q;
  assign MEM_bus_err     = bus_err_q;
  assign MEM_rd          = mem_rd_q;
  assign MEM_rd_vld      = mem_rd_vld_q;
  assign MEM_x_rd        = mem_x_rd_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, timeout and reset abort.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic [4:0]  EX_rd;
  logic        EX_rd_vld;
  logic [31:0] EX_x_rd;
  logic [31:0] EX_MEM_addr;
  logic [3:0]  EX_MEM_rden;
  logic        EX_MEM_rden_SEXT;
  logic [3:0]  EX_MEM_wren;
  logic [31:0] EX_MEM_wrdata;
  logic        MEM_stall;
  logic        MEM_bus_err;
  logic [4:0]  MEM_rd;
  logic        MEM_rd_vld;
  logic [31:0] MEM_x_rd;

  int checks = 0;
  int errors = 0;

  mem_access_if dbus ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .EX_rd            (EX_rd),
    .EX_rd_vld        (EX_rd_vld),
    .EX_x_rd          (EX_x_rd),
    .EX_MEM_addr      (EX_MEM_addr),
    .EX_MEM_rden      (EX_MEM_rden),
    .EX_MEM_rden_SEXT (EX_MEM_rden_SEXT),
    .EX_MEM_wren      (EX_MEM_wren),
    .EX_MEM_wrdata    (EX_MEM_wrdata),
    .dbus             (dbus.master),
    .MEM_stall        (MEM_stall),
    .MEM_bus_err      (MEM_bus_err),
    .MEM_rd           (MEM_rd),
    .MEM_rd_vld       (MEM_rd_vld),
    .MEM_x_rd         (MEM_x_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    EX_MEM_rden = 4'h0; EX_MEM_wren = 4'h0; EX_MEM_rden_SEXT = 1'b0;
    EX_rd_vld = 1'b0; dbus.dbus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    EX_rd = 5'h0; EX_x_rd = 32'h0; EX_MEM_addr = 32'h0; EX_MEM_wrdata = 32'h0;
    set_idle();
    dbus.dbus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dbus.dbus_req, dbus.dbus_we, dbus.dbus_be, MEM_bus_err, MEM_rd_vld, MEM_stall} !== 9'h0) begin
      errors++; $display("FAIL reset_ctrl: got req=%b we=%b be=%b err=%b vld=%b stall=%b, need all 0",
        dbus.dbus_req, dbus.dbus_we, dbus.dbus_be, MEM_bus_err, MEM_rd_vld, MEM_stall);
    end
    checks++;
    if ({dbus.dbus_addr, dbus.dbus_wdata, MEM_x_rd, MEM_rd} !== 101'h0) begin
      errors++; $display("FAIL reset_data: got addr=%h wdata=%h x_rd=%h rd=%0d, need 0",
        dbus.dbus_addr, dbus.dbus_wdata, MEM_x_rd, MEM_rd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    tick();
    EX_x_rd = 32'h1234; EX_rd = 5'd5; EX_rd_vld = 1'b1;
    @(negedge clk);
    checks++;
    if (MEM_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b need 0", MEM_stall); end
    tick();
    @(negedge clk);
    checks++;
    if ({MEM_x_rd, MEM_rd, MEM_rd_vld} !== {32'h1234, 5'd5, 1'b1}) begin
      errors++; $display("FAIL alu_pass: got x_rd=%h rd=%0d vld=%b need 1234/5/1", MEM_x_rd, MEM_rd, MEM_rd_vld);
    end
  endtask

  task automatic test_lb_sext();
    tick();
    EX_MEM_addr = 32'h103; EX_MEM_rden = 4'b1000; EX_MEM_rden_SEXT = 1'b1;
    EX_rd = 5'd7; EX_rd_vld = 1'b1; EX_x_rd = 32'h0;
    @(negedge clk);
    checks++;
    if (MEM_stall !== 1'b1) begin errors++; $display("FAIL lb_stall_accept: got %b need 1", MEM_stall); end
    tick();
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h80AABBCC;
    @(negedge clk);
    checks++;
    if ({dbus.dbus_req, dbus.dbus_we, dbus.dbus_addr, dbus.dbus_be, MEM_stall} !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL lb_bus: got req=%b we=%b addr=%h be=%b stall=%b need 1/0/100/1000/0",
        dbus.dbus_req, dbus.dbus_we, dbus.dbus_addr, dbus.dbus_be, MEM_stall);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if ({MEM_x_rd, MEM_rd, MEM_rd_vld, dbus.dbus_req} !== {32'hFFFFFF80, 5'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lb_result: got x_rd=%h rd=%0d vld=%b req=%b need FFFFFF80/7/1/0",
        MEM_x_rd, MEM_rd, MEM_rd_vld, dbus.dbus_req);
    end
  endtask

  task automatic test_lhu_wait();
    tick();
    EX_MEM_addr = 32'h102; EX_MEM_rden = 4'b1100; EX_MEM_rden_SEXT = 1'b0;
    EX_rd = 5'd9; EX_rd_vld = 1'b1;
    @(negedge clk);
    checks++;
    if (MEM_stall !== 1'b1) begin errors++; $display("FAIL lhu_stall_accept: got %b need 1", MEM_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({dbus.dbus_req, dbus.dbus_addr, dbus.dbus_be, MEM_stall, MEM_rd_vld} !== {1'b1, 32'h100, 4'b1100, 1'b1, 1'b0}) begin
        errors++; $display("FAIL lhu_wait%0d: got req=%b addr=%h be=%b stall=%b vld=%b need 1/100/1100/1/0",
          i, dbus.dbus_req, dbus.dbus_addr, dbus.dbus_be, MEM_stall, MEM_rd_vld);
      end
    end
    tick();
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'hF00D0000;
    @(negedge clk);
    checks++;
    if ({dbus.dbus_req, dbus.dbus_addr, MEM_stall} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL lhu_ack: got req=%b addr=%h stall=%b need 1/100/0", dbus.dbus_req, dbus.dbus_addr, MEM_stall);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if ({MEM_x_rd, MEM_rd, MEM_rd_vld, dbus.dbus_req} !== {32'h0000F00D, 5'd9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lhu_result: got x_rd=%h rd=%0d vld=%b req=%b need 0000F00D/9/1/0",
        MEM_x_rd, MEM_rd, MEM_rd_vld, dbus.dbus_req);
    end
  endtask

  task automatic test_sb();
    tick();
    EX_MEM_addr = 32'h21; EX_MEM_wren = 4'b0010; EX_MEM_wrdata = 32'h5A5A5A5A;
    EX_rd = 5'd0; EX_rd_vld = 1'b0;
    tick();
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({dbus.dbus_req, dbus.dbus_we, dbus.dbus_addr, dbus.dbus_be, dbus.dbus_wdata} !== {1'b1, 1'b1, 32'h20, 4'b0010, 32'h5A5A5A5A}) begin
      errors++; $display("FAIL sb_bus: got req=%b we=%b addr=%h be=%b wdata=%h need 1/1/20/0010/5A5A5A5A",
        dbus.dbus_req, dbus.dbus_we, dbus.dbus_addr, dbus.dbus_be, dbus.dbus_wdata);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if ({MEM_rd_vld, dbus.dbus_req} !== 2'b00) begin
      errors++; $display("FAIL sb_result: got vld=%b req=%b need 0/0", MEM_rd_vld, dbus.dbus_req);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    EX_x_rd = 32'h77; EX_rd = 5'd1; EX_rd_vld = 1'b1;
    tick();
    EX_MEM_addr = 32'h44; EX_MEM_wren = 4'b0001; EX_MEM_rden = 4'b1111;
    EX_MEM_wrdata = 32'h11111111; EX_rd_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({MEM_stall, MEM_x_rd, MEM_rd_vld} !== {1'b1, 32'h77, 1'b1}) begin
      errors++; $display("FAIL b2b_accept: got stall=%b x_rd=%h vld=%b need 1/77/1", MEM_stall, MEM_x_rd, MEM_rd_vld);
    end
    tick();
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({dbus.dbus_we, dbus.dbus_be} !== {1'b1, 4'b0001}) begin
      errors++; $display("FAIL store_wins: got we=%b be=%b need 1/0001", dbus.dbus_we, dbus.dbus_be);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if ({MEM_x_rd, MEM_rd_vld} !== {32'h77, 1'b0}) begin
      errors++; $display("FAIL store_xrd_hold: got x_rd=%h vld=%b need 77/0", MEM_x_rd, MEM_rd_vld);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_seen   = 0;
    bit aborted    = 1'b0;
    tick();
    EX_MEM_addr = 32'h40; EX_MEM_rden = 4'b1111; EX_rd = 5'd4; EX_rd_vld = 1'b1;
    for (int i = 0; i < 8 && !aborted; i++) begin
      tick();
      @(negedge clk);
      if (dbus.dbus_req) req_cycles++;
      if (MEM_bus_err) err_seen++;
      if (dbus.dbus_req && !MEM_stall) aborted = 1'b1;
    end
    checks++;
    if (!aborted || req_cycles != 4 || err_seen != 0) begin
      errors++; $display("FAIL timeout_req: got aborted=%b req_cycles=%0d early_err=%0d need 1/4/0",
        aborted, req_cycles, err_seen);
    end
    tick();
    set_idle();
    EX_x_rd = 32'hCAFE; EX_rd = 5'd3; EX_rd_vld = 1'b1;
    @(negedge clk);
    checks++;
    if ({MEM_bus_err, dbus.dbus_req, MEM_rd_vld, MEM_stall} !== 4'b1000) begin
      errors++; $display("FAIL timeout_err: got err=%b req=%b vld=%b stall=%b need 1/0/0/0",
        MEM_bus_err, dbus.dbus_req, MEM_rd_vld, MEM_stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({MEM_bus_err, MEM_x_rd, MEM_rd, MEM_rd_vld} !== {1'b0, 32'hCAFE, 5'd3, 1'b1}) begin
      errors++; $display("FAIL timeout_after: got err=%b x_rd=%h rd=%0d vld=%b need 0/CAFE/3/1",
        MEM_bus_err, MEM_x_rd, MEM_rd, MEM_rd_vld);
    end
  endtask

  task automatic test_reset_busy();
    tick();
    EX_MEM_addr = 32'h80; EX_MEM_rden = 4'b1111; EX_rd = 5'd6; EX_rd_vld = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (dbus.dbus_req !== 1'b1) begin errors++; $display("FAIL rstb_busy: got req=%b need 1", dbus.dbus_req); end
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dbus.dbus_req, MEM_rd_vld, MEM_x_rd, MEM_rd, dbus.dbus_be} !== 43'h0) begin
      errors++; $display("FAIL rstb_drop: got req=%b vld=%b x_rd=%h rd=%0d be=%b need all 0",
        dbus.dbus_req, MEM_rd_vld, MEM_x_rd, MEM_rd, dbus.dbus_be);
    end
    EX_MEM_addr = 32'h10; EX_MEM_rden = 4'b0011; EX_MEM_rden_SEXT = 1'b1; EX_rd = 5'd12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h12348001;
    @(negedge clk);
    checks++;
    if ({dbus.dbus_req, dbus.dbus_addr, dbus.dbus_be} !== {1'b1, 32'h10, 4'b0011}) begin
      errors++; $display("FAIL rstb_reload_bus: got req=%b addr=%h be=%b need 1/10/0011",
        dbus.dbus_req, dbus.dbus_addr, dbus.dbus_be);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if ({MEM_x_rd, MEM_rd, MEM_rd_vld} !== {32'hFFFF8001, 5'd12, 1'b1}) begin
      errors++; $display("FAIL rstb_reload_result: got x_rd=%h rd=%0d vld=%b need FFFF8001/12/1",
        MEM_x_rd, MEM_rd, MEM_rd_vld);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_sext();
    test_lhu_wait();
    test_sb();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
